// File: rtl/seg_codec_pkg.sv
// Segment pattern constants and the segment-to-hex classifier shared by the
// reader and the segment decoder's tests.
package seg_codec_pkg;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] value;
  } seg_entry_t;

  localparam int ENTRY_W = $bits(seg_entry_t);

  // Active-low {A,B,C,D,E,F,G}
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic seg_entry_t seg_to_hex(input logic [6:0] seg);
    seg_entry_t r;
    r = '{err: 1'b1, blank: 1'b0, value: 4'h0};
    case (seg)
      SEG_0:     r.err = 1'b0;
      SEG_1:     r = '{err: 1'b0, blank: 1'b0, value: 4'h1};
      SEG_2:     r = '{err: 1'b0, blank: 1'b0, value: 4'h2};
      SEG_3:     r = '{err: 1'b0, blank: 1'b0, value: 4'h3};
      SEG_4:     r = '{err: 1'b0, blank: 1'b0, value: 4'h4};
      SEG_5:     r = '{err: 1'b0, blank: 1'b0, value: 4'h5};
      SEG_6:     r = '{err: 1'b0, blank: 1'b0, value: 4'h6};
      SEG_7:     r = '{err: 1'b0, blank: 1'b0, value: 4'h7};
      SEG_8:     r = '{err: 1'b0, blank: 1'b0, value: 4'h8};
      SEG_9:     r = '{err: 1'b0, blank: 1'b0, value: 4'h9};
      SEG_A:     r = '{err: 1'b0, blank: 1'b0, value: 4'hA};
      SEG_B:     r = '{err: 1'b0, blank: 1'b0, value: 4'hB};
      SEG_C:     r = '{err: 1'b0, blank: 1'b0, value: 4'hC};
      SEG_D:     r = '{err: 1'b0, blank: 1'b0, value: 4'hD};
      SEG_E:     r = '{err: 1'b0, blank: 1'b0, value: 4'hE};
      SEG_F:     r = '{err: 1'b0, blank: 1'b0, value: 4'hF};
      SEG_BLANK: r = '{err: 1'b0, blank: 1'b1, value: 4'h0};
      default:   r = '{err: 1'b1, blank: 1'b0, value: 4'h0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_fifo.sv
// Show-ahead synchronous FIFO; head data is visible whenever not empty.
// A push while full is accepted only if a pop frees a slot on the same edge.
module seg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Watches an active-low seven-segment bus, commits each newly settled pattern
// as a classified hex/blank/error entry and queues it for a valid/ready reader.
module seven_seg_reader
  import seg_codec_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_seg,
  output logic       o_valid,
  input  logic       i_ready,
  output logic [3:0] o_value,
  output logic       o_blank,
  output logic       o_err,
  output logic       o_overflow
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0] r_s;
  logic [6:0] r_last;
  logic [7:0] r_cnt;
  logic       r_overflow;

  logic       w_same;
  logic [7:0] w_cnt_next;
  logic       w_commit;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  seg_entry_t w_new;
  seg_entry_t w_head;

  // Commit on the edge the run length reaches the threshold, so the entry
  // lands STABLE_CYCLES-1 edges after the first capture of the new pattern.
  always_comb begin
    w_same = (i_seg == r_s);
    if (!w_same)              w_cnt_next = 8'd1;
    else if (r_cnt == STABLE) w_cnt_next = r_cnt;
    else                      w_cnt_next = r_cnt + 8'd1;
    w_commit = (w_cnt_next == STABLE) && (r_cnt != STABLE) && (i_seg != r_last);
  end

  assign w_new = seg_to_hex(i_seg);
  assign w_pop = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s        <= SEG_BLANK;
      r_cnt      <= STABLE;
      r_last     <= SEG_BLANK;
      r_overflow <= 1'b0;
    end else begin
      r_s   <= i_seg;
      r_cnt <= w_cnt_next;
      if (w_commit) r_last <= i_seg;
      if (w_commit && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  seg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_commit),
    .i_data  (w_new),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_valid    = ~w_empty;
  assign o_value    = o_valid ? w_head.value : 4'd0;
  assign o_blank    = o_valid & w_head.blank;
  assign o_err      = o_valid & w_head.err;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Self-checking bench: directed scenarios plus random segment traffic, compared
// every cycle against a queue-based model of settle/commit/FIFO behaviour.
module tb_seven_seg_reader;

  localparam int STABLE = 4;
  localparam int DEPTH  = 4;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic [6:0] i_seg;
  logic       i_ready;
  logic       o_valid;
  logic [3:0] o_value;
  logic       o_blank;
  logic       o_err;
  logic       o_overflow;

  always #5 clk = ~clk;

  seven_seg_reader #(.STABLE_CYCLES(STABLE), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (i_rst_n),
    .i_seg      (i_seg),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_value    (o_value),
    .o_blank    (o_blank),
    .o_err      (o_err),
    .o_overflow (o_overflow)
  );

  typedef struct { logic [3:0] v; logic b; logic e; } ent_t;

  logic [6:0] pats [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  localparam logic [6:0] BLANK   = 7'b1111111;
  localparam logic [6:0] ILLEGAL = 7'b1110111;

  ent_t       q[$];
  logic [6:0] m_s;
  logic [6:0] m_last;
  int         m_run;
  logic       m_ovf;
  int         errors = 0;
  int         checks = 0;

  function automatic ent_t classify(input logic [6:0] s);
    ent_t r;
    r.v = 4'd0; r.b = 1'b0; r.e = 1'b1;
    if (s == BLANK) begin
      r.e = 1'b0; r.b = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++)
        if (pats[i] == s) begin r.e = 1'b0; r.v = i[3:0]; end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_s = BLANK; m_last = BLANK; m_run = STABLE; m_ovf = 1'b0;
  endtask

  // One clock edge of the reference behaviour, applied with the inputs seen at it.
  task automatic model_edge(input logic [6:0] seg, input logic rdy);
    bit pop, full, commit;
    int prev;
    pop  = (q.size() != 0) && rdy;
    full = (q.size() == DEPTH);
    prev = m_run;
    if (seg != m_s) m_run = 1;
    else if (m_run < STABLE) m_run++;
    m_s = seg;
    commit = (m_run == STABLE) && (prev < STABLE) && (seg != m_last);
    if (pop) void'(q.pop_front());
    if (commit) begin
      m_last = seg;
      if (full && !pop) m_ovf = 1'b1;
      else q.push_back(classify(seg));
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".valid"}, o_valid, q.size() != 0);
    if (q.size() != 0) begin
      check({tag, ".value"}, o_value, q[0].v);
      check({tag, ".blank"}, o_blank, q[0].b);
      check({tag, ".err"},   o_err,   q[0].e);
    end else begin
      check({tag, ".value0"}, o_value, 0);
      check({tag, ".blank0"}, o_blank, 0);
      check({tag, ".err0"},   o_err,   0);
    end
    check({tag, ".ovf"}, o_overflow, m_ovf);
  endtask

  task automatic cyc(input string tag, input logic [6:0] seg, input logic rdy);
    @(negedge clk);
    i_seg = seg; i_ready = rdy;
    @(posedge clk);
    model_edge(seg, rdy);
    #1 compare(tag);
  endtask

  task automatic hold(input string tag, input logic [6:0] seg, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(tag, seg, rdy);
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 i_rst_n = 1'b0;
    #1 model_reset();
    compare(tag);
    repeat (2) @(posedge clk);
    i_seg = BLANK; i_ready = 1'b0;
    #2 i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_seg = BLANK; i_ready = 1'b0;
    model_reset();
    #12 compare("reset");
    @(posedge clk);
    #2 i_rst_n = 1'b1;

    // Digit 2 settles after 4 edges, then is popped.
    hold("t1", pats[2], 4, 1'b0);
    check("t1_valid_after_4", o_valid, 1);
    check("t1_value", o_value, 2);
    cyc("t1_pop", pats[2], 1'b1);
    check("t1_empty", o_valid, 0);

    // Short glitch and return to the last committed pattern.
    hold("t2_glitch", pats[1], 2, 1'b0);
    hold("t2_back", pats[2], 6, 1'b0);
    check("t2_no_entry", o_valid, 0);

    // F, blank, F streamed out.
    hold("t3_f", pats[15], 6, 1'b1);
    hold("t3_blank", BLANK, 6, 1'b1);
    hold("t3_f2", pats[15], 6, 1'b1);

    // Illegal pattern.
    hold("t4", ILLEGAL, 4, 1'b0);
    check("t4_err", o_err, 1);
    check("t4_value", o_value, 0);
    cyc("t4_pop", ILLEGAL, 1'b1);

    // Overflow with five digits and no reader.
    for (int d = 1; d <= 5; d++) hold("t5_fill", pats[d], 4, 1'b0);
    check("t5_overflow", o_overflow, 1);
    check("t5_head", o_value, 1);
    hold("t5_drain", pats[5], 5, 1'b1);
    check("t5_drained", o_valid, 0);

    // Full FIFO with a pop on the commit edge of digit 6.
    async_reset("t6_reset");
    for (int d = 1; d <= 4; d++) hold("t6_fill", pats[d], 4, 1'b0);
    hold("t6_six", pats[6], 3, 1'b0);
    cyc("t6_commit", pats[6], 1'b1);
    check("t6_no_ovf", o_overflow, 0);
    for (int i = 0; i < 3; i++) cyc("t6_drain", pats[6], 1'b1);
    check("t6_last_is_6", o_value, 6);
    cyc("t6_final", pats[6], 1'b1);
    check("t6_empty", o_valid, 0);

    // Reset mid-settle with two entries queued.
    hold("t7_a", pats[7], 4, 1'b0);
    hold("t7_b", pats[8], 4, 1'b0);
    hold("t7_partial", pats[9], 2, 1'b0);
    async_reset("t7_reset");
    hold("t7_after", BLANK, 6, 1'b1);

    // Random traffic with random hold lengths and reader back-pressure.
    for (int n = 0; n < 300; n++) begin
      logic [6:0] s;
      int sel, len;
      sel = $urandom_range(0, 19);
      if (sel < 16)       s = pats[sel];
      else if (sel < 18)  s = BLANK;
      else                s = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) cyc("rand", s, 1'($urandom_range(0, 2) != 0));
      if (n == 150) async_reset("rand_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
